// File: rtl/fp_mult_pipe_hs.sv
// Parametrised floating-point multiplier with a four-stage pipeline and valid/ready handshake.
// Subnormal inputs are treated as zero, rounding is nearest-even, and underflow flushes to zero.
module fp_mult_pipe_hs #(
   parameter int EXP_W = 5,
   parameter int MAN_W = 10,
   localparam int DW = 1 + EXP_W + MAN_W
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] a,
   input  logic [DW-1:0] b,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] result,
   output logic [4:0]    flags
);

   localparam int BIAS = 2**(EXP_W-1) - 1;
   localparam int PW   = 2*MAN_W + 2;
   localparam int EW2  = EXP_W + 2;
   localparam logic signed [EW2-1:0] ES_MAX  = EW2'(2**EXP_W - 1);
   localparam logic signed [EW2-1:0] ES_ZERO = '0;

   logic advance;

   // Stage 1: unpacked operands and operand classes
   logic             v1, sa1, sb1, nan1, inf1, zero1;
   logic [EXP_W-1:0] ea1, eb1;
   logic [MAN_W-1:0] ma1, mb1;

   // Stage 2: raw product
   logic                  v2, sp2, nan2, inf2, zero2;
   logic [PW-1:0]         mp2;
   logic signed [EW2-1:0] es2;

   // Stage 3: normalised and rounded
   logic                  v3, sp3, nan3, inf3, zero3, inex3;
   logic [MAN_W-1:0]      man3;
   logic signed [EW2-1:0] es3;

   logic aExpMax, aExpZero, aManZero, bExpMax, bExpZero, bManZero;
   logic aNan, bNan, aInf, bInf;
   logic [PW-1:0]         mpNext;
   logic signed [EW2-1:0] esNext;
   logic [PW-2:0]         normLow;
   logic signed [EW2-1:0] esNorm, esRound;
   logic [MAN_W-1:0]      manTrunc;
   logic                  guardBit, stickyBit, roundUp;
   logic [MAN_W:0]        manSum;
   logic [DW-1:0]         resNext;
   logic [4:0]            flagsNext;

   assign advance  = !out_valid | out_ready;
   assign in_ready = advance;

   assign aExpMax  = &a[DW-2:MAN_W];
   assign aExpZero = ~|a[DW-2:MAN_W];
   assign aManZero = ~|a[MAN_W-1:0];
   assign bExpMax  = &b[DW-2:MAN_W];
   assign bExpZero = ~|b[DW-2:MAN_W];
   assign bManZero = ~|b[MAN_W-1:0];
   assign aNan     = aExpMax & !aManZero;
   assign bNan     = bExpMax & !bManZero;
   assign aInf     = aExpMax & aManZero;
   assign bInf     = bExpMax & bManZero;

   assign mpNext = PW'({1'b1, ma1}) * PW'({1'b1, mb1});
   assign esNext = EW2'({2'b00, ea1}) + EW2'({2'b00, eb1}) - EW2'(BIAS);

   // Product lies in [1,4): bring it to [1,2) and keep everything below the
   // retained mantissa for the guard and sticky bits.
   always_comb begin
      normLow   = mp2[PW-1] ? mp2[PW-2:0] : {mp2[PW-3:0], 1'b0};
      esNorm    = mp2[PW-1] ? es2 + EW2'(1) : es2;
      manTrunc  = normLow[PW-2 -: MAN_W];
      guardBit  = normLow[PW-2-MAN_W];
      stickyBit = |normLow[PW-3-MAN_W:0];
      roundUp   = guardBit & (stickyBit | manTrunc[0]);
      manSum    = {1'b0, manTrunc} + (MAN_W+1)'(roundUp);
      esRound   = manSum[MAN_W] ? esNorm + EW2'(1) : esNorm;
   end

   // Exception resolution, highest priority first.
   always_comb begin
      resNext   = {sp3, es3[EXP_W-1:0], man3};
      flagsNext = {3'b000, inex3, 1'b0};
      if (nan3 || (zero3 && inf3)) begin
         resNext   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
         flagsNext = 5'b10000;
      end else if (inf3) begin
         resNext   = {sp3, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         flagsNext = 5'b00000;
      end else if (zero3) begin
         resNext   = {sp3, {(DW-1){1'b0}}};
         flagsNext = 5'b00001;
      end else if (es3 >= ES_MAX) begin
         resNext   = {sp3, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         flagsNext = 5'b01010;
      end else if (es3 <= ES_ZERO) begin
         resNext   = {sp3, {(DW-1){1'b0}}};
         flagsNext = 5'b00111;
      end
   end

   // All stages move together on advance; bubbles travel as ordinary stages.
   always_ff @(posedge clk) begin
      if (rst) begin
         v1        <= 1'b0;
         v2        <= 1'b0;
         v3        <= 1'b0;
         out_valid <= 1'b0;
         result    <= '0;
         flags     <= '0;
      end else if (advance) begin
         v1    <= in_valid;
         sa1   <= a[DW-1];
         sb1   <= b[DW-1];
         ea1   <= a[DW-2:MAN_W];
         eb1   <= b[DW-2:MAN_W];
         ma1   <= a[MAN_W-1:0];
         mb1   <= b[MAN_W-1:0];
         nan1  <= aNan | bNan;
         inf1  <= aInf | bInf;
         zero1 <= aExpZero | bExpZero;

         v2    <= v1;
         sp2   <= sa1 ^ sb1;
         mp2   <= mpNext;
         es2   <= esNext;
         nan2  <= nan1;
         inf2  <= inf1;
         zero2 <= zero1;

         v3    <= v2;
         sp3   <= sp2;
         man3  <= manSum[MAN_W-1:0];
         es3   <= esRound;
         inex3 <= guardBit | stickyBit;
         nan3  <= nan2;
         inf3  <= inf2;
         zero3 <= zero2;

         out_valid <= v3;
         result    <= resNext;
         flags     <= flagsNext;
      end
   end

endmodule
